// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op codes, sequencer state encoding and divide-by-zero constant shared by the HI/LO unit
package muldiv_pkg;
  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [31:0] LO_DIV0 = 32'hFFFF_FFFF;
  typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_SETTLE, ST_WAIT} state_t;
  function automatic logic is_div(input logic [2:0] code);
    return code == OP_DIV || code == OP_DIVU;
  endfunction
endpackage

// File: rtl/muldiv_mul.sv
// muldiv_mul: combinational 32x32 multiplier; sgn selects two's-complement operands, 64-bit result
module muldiv_mul (
  input  logic        sgn,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] prod
);
  logic [63:0] a_ext, b_ext;
  // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then correct for both modes
  always_comb begin
    a_ext = {{32{sgn & a[31]}}, a};
    b_ext = {{32{sgn & b[31]}}, b};
    prod  = a_ext * b_ext;
  end
endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: HI/LO register owner; multiplies in-block, sequences the external divider core
module hilo_muldiv_ctrl
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  input  logic        div_done
);
  state_t      state, state_nxt;
  logic [63:0] prod;
  logic [31:0] hi_nxt, lo_nxt, dvd_nxt, dvs_nxt;
  logic        done_nxt, sgn_nxt, accept;

  muldiv_mul u_mul (
    .sgn (op_code == OP_MULT),
    .a   (op_a),
    .b   (op_b),
    .prod(prod)
  );

  assign accept    = state == ST_IDLE && op_valid;
  assign busy      = state != ST_IDLE;
  assign div_start = state == ST_LAUNCH;

  // State register; reset aborts any divide in flight without touching the core
  always_ff @(posedge clk)
    state <= rst_n ? state_nxt : ST_IDLE;

  // Only a divide with a nonzero divisor leaves IDLE; SETTLE blinds us to the core's stale idle flag
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   state_nxt = (op_valid && is_div(op_code) && op_b != '0) ? ST_LAUNCH : ST_IDLE;
      ST_LAUNCH: state_nxt = ST_SETTLE;
      ST_SETTLE: state_nxt = ST_WAIT;
      ST_WAIT:   state_nxt = div_done ? ST_IDLE : ST_WAIT;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Next HI/LO and divider operands: divider writeback in WAIT, otherwise the accepted op
  always_comb begin
    hi_nxt   = hi;
    lo_nxt   = lo;
    done_nxt = 1'b0;
    sgn_nxt  = div_signed;
    dvd_nxt  = div_dividend;
    dvs_nxt  = div_divisor;
    if (state == ST_WAIT && div_done) begin
      hi_nxt   = div_r;
      lo_nxt   = div_q;
      done_nxt = 1'b1;
    end else if (accept) begin
      case (op_code)
        OP_MULT, OP_MULTU: begin
          {hi_nxt, lo_nxt} = prod;
          done_nxt = 1'b1;
        end
        OP_MTHI: begin
          hi_nxt   = op_a;
          done_nxt = 1'b1;
        end
        OP_MTLO: begin
          lo_nxt   = op_a;
          done_nxt = 1'b1;
        end
        OP_DIV, OP_DIVU: begin
          if (op_b == '0) begin
            hi_nxt   = op_a;
            lo_nxt   = LO_DIV0;
            done_nxt = 1'b1;
          end else begin
            sgn_nxt = op_code == OP_DIV;
            dvd_nxt = op_a;
            dvs_nxt = op_b;
          end
        end
        default: ;
      endcase
    end
  end

  // Result and operand registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi           <= '0;
      lo           <= '0;
      done         <= 1'b0;
      div_signed   <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
    end else begin
      hi           <= hi_nxt;
      lo           <= lo_nxt;
      done         <= done_nxt;
      div_signed   <= sgn_nxt;
      div_dividend <= dvd_nxt;
      div_divisor  <= dvs_nxt;
    end
  end
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb_hilo_muldiv_ctrl: directed and random checks of the HI/LO sequencer against a timeline model
module tb_hilo_muldiv_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op_code = 3'd0;
  logic [31:0] op_a = '0, op_b = '0;
  logic        busy, done, div_start, div_signed;
  logic [31:0] hi, lo, div_dividend, div_divisor, div_q, div_r;
  logic        div_done, stale = 1'b0;
  int          tests = 0, fails = 0;

  always #5 clk = ~clk;

  hilo_muldiv_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_code(op_code),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .div_start(div_start), .div_signed(div_signed), .div_dividend(div_dividend),
    .div_divisor(div_divisor), .div_q(div_q), .div_r(div_r), .div_done(div_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void divref(input logic s, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    if (s) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Divider core stand-in: loads on start, idle flag drops for 32 iterations; stale can force it high
  int          core_cnt = 0;
  logic [31:0] core_q = '0, core_r = '0;
  always @(posedge clk) begin
    if (div_start) begin
      core_cnt <= 32;
      divref(div_signed, div_dividend, div_divisor, core_q, core_r);
    end else if (core_cnt > 0) core_cnt <= core_cnt - 1;
  end
  assign div_done = (core_cnt == 0) | stale;
  assign div_q = core_q;
  assign div_r = core_r;

  // Reference: a divide occupies 34 edges after acceptance, then writes remainder/quotient
  logic [31:0] m_hi, m_lo, m_dvd, m_dvs, m_q, m_r;
  logic        m_done, m_sgn;
  int          m_left = 0;
  always @(posedge clk) begin
    m_done = 1'b0;
    if (!rst_n) begin
      m_hi = 0; m_lo = 0; m_left = 0; m_sgn = 0; m_dvd = 0; m_dvs = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_hi = m_r; m_lo = m_q; m_done = 1'b1;
      end
    end else if (op_valid) begin
      case (op_code)
        3'd1: begin {m_hi, m_lo} = longint'(int'(op_a)) * longint'(int'(op_b)); m_done = 1'b1; end
        3'd2: begin {m_hi, m_lo} = {32'd0, op_a} * {32'd0, op_b}; m_done = 1'b1; end
        3'd5: begin m_hi = op_a; m_done = 1'b1; end
        3'd6: begin m_lo = op_a; m_done = 1'b1; end
        3'd3, 3'd4: begin
          if (op_b == 0) begin
            m_hi = op_a; m_lo = 32'hFFFF_FFFF; m_done = 1'b1;
          end else begin
            m_sgn = op_code == 3'd3; m_dvd = op_a; m_dvs = op_b; m_left = 34;
            divref(m_sgn, op_a, op_b, m_q, m_r);
          end
        end
        default: ;
      endcase
    end
  end

  // Every-cycle comparison against the model, just after each rising edge
  always @(posedge clk) begin
    #1;
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("busy", {31'd0, busy}, {31'd0, m_left > 0});
    chk("done", {31'd0, done}, {31'd0, m_done});
    chk("div_start", {31'd0, div_start}, {31'd0, m_left == 34});
    chk("div_signed", {31'd0, div_signed}, {31'd0, m_sgn});
    chk("div_dividend", div_dividend, m_dvd);
    chk("div_divisor", div_divisor, m_dvs);
  end

  task automatic issue(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1; op_code = c; op_a = a; op_b = b;
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", {31'd0, done}, 32'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 4)
      0: return 32'd0;
      1: return $urandom % 16;
      2: return 32'hFFFF_FFFF - ($urandom % 4);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    issue(3'd1, 32'hFFFF_FFFE, 32'd3);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    chk("mult_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    chk("mult_done_pulse", {31'd0, done}, 32'd0);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    chk("div_start_pulse", {31'd0, div_start}, 32'd1);
    wait_done(n);
    chk("div_latency", n, 32'd34);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    issue(3'd4, 32'd100, 32'd0);
    chk("div0_start", {31'd0, div_start}, 32'd0);
    chk("div0_busy", {31'd0, busy}, 32'd0);
    chk("div0_done", {31'd0, done}, 32'd1);
    chk("div0_hi", hi, 32'd100);
    chk("div0_lo", lo, 32'hFFFF_FFFF);
    issue(3'd4, 32'd100, 32'd7);
    @(negedge clk);
    stale = 1'b1;
    op_valid = 1'b1; op_code = 3'd5; op_a = 32'hDEAD_BEEF;
    @(negedge clk);
    stale = 1'b0;
    chk("stale_busy", {31'd0, busy}, 32'd1);
    chk("stale_no_done", {31'd0, done}, 32'd0);
    repeat (5) @(negedge clk);
    op_valid = 1'b0;
    wait_done(n);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
    issue(3'd3, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    rst_n = 1'b1;
    issue(3'd3, 32'd9, 32'd3);
    wait_done(n);
    chk("div93_latency", n, 32'd34);
    chk("div93_lo", lo, 32'd3);
    chk("div93_hi", hi, 32'd0);
    issue(3'd6, 32'h1234_5678, 32'd0);
    chk("b2b_mtlo", lo, 32'h1234_5678);
    for (int i = 0; i < 3000; i++) begin
      op_valid = ($urandom % 3) != 0;
      op_code = 3'($urandom % 8);
      op_a = pick();
      op_b = pick();
      if (op_a == 32'h8000_0000 && op_b == 32'hFFFF_FFFF) op_b = 32'd1;
      stale = (m_left == 33) ? 1'($urandom % 2) : 1'b0;
      rst_n = ($urandom % 400) != 0;
      @(negedge clk);
    end
    op_valid = 1'b0; stale = 1'b0; rst_n = 1'b1;
    repeat (40) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
